conv_core: RTL and testbench

Streaming 1-D convolution engine for the convolution subsystem. It accepts one `Conv::data_t` sample per input handshake and shifts it into a `Conv::LEN`-deep window whose initial contents are zero. It returns one `Conv::result_t` dot product of that window with the kernel per output handshake. The block sits between the sample source and the result consumer, and is the unit the convolution scoreboard observes on both handshakes. It uses a single shared multiplier, so each result takes `LEN` multiply-accumulate cycles.

---
 rtl/conv_core.sv | 114 +++++++++++
 tb/tb_conv_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_core.sv
// Streaming 1-D convolution engine: shifts samples into a LEN-deep window and
// produces the window/kernel dot product using one shared multiply-accumulate.
package Conv;
    localparam int WIDTH = 8;
    localparam int LEN   = 4;

    typedef logic [WIDTH-1:0]   data_t;
    typedef logic [2*WIDTH-1:0] result_t;

    typedef struct packed {
        data_t [LEN-1:0] data;
    } data_vector;
endpackage

module conv_core (
    input  logic             clk,
    input  logic             rst,
    input  Conv::data_t      in_data,
    input  Conv::data_vector kernel,
    input  logic             in_valid,
    output logic             in_ready,
    output Conv::result_t    result,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int IDX_W = (Conv::LEN > 1) ? $clog2(Conv::LEN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    Conv::result_t    acc_q, acc_d;
    Conv::data_t      win_q [Conv::LEN];
    Conv::data_t      win_d [Conv::LEN];
    Conv::data_vector kreg_q, kreg_d;
    logic             out_valid_q, out_valid_d;
    Conv::result_t    prod;

    // Operands are zero-extended to the full result width before the multiply.
    assign prod = Conv::result_t'(win_q[idx_q]) * Conv::result_t'(kreg_q.data[idx_q]);

    // Masking in_ready during reset keeps a sample offered alongside rst from looking accepted.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = acc_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        win_d   = win_q;
        kreg_d  = kreg_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    for (int i = 0; i < Conv::LEN - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[Conv::LEN-1] = in_data;
                    kreg_d  = kernel;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + prod;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(Conv::LEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            kreg_q      <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < Conv::LEN; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            kreg_q      <= kreg_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < Conv::LEN; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

endmodule

// File: tb/tb_conv_core.sv
// Directed, table-driven bench for conv_core with hand-computed results for
// the streaming, wrap-around, backpressure, kernel-capture and reset cases.
module tb_conv_core;

    logic             clk = 1'b0;
    logic             rst;
    Conv::data_t      in_data;
    Conv::data_vector kernel;
    logic             in_valid;
    logic             in_ready;
    Conv::result_t    result;
    logic             out_valid;
    logic             out_ready;

    int vecCount   = 0;
    int missCount  = 0;
    int cyc        = 0;
    int prevAccept = -1;

    typedef struct {
        logic        doReset;
        logic        chkGap;
        logic [7:0]  din;
        logic [31:0] kern;
        logic [15:0] expRes;
    } vec_t;

    vec_t vecs [10];

    conv_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .kernel    (kernel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitValid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic applyReset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("in_ready after reset", 32'(in_ready), 32'd1);
        prevAccept = -1;
    endtask

    // Offers one sample, optionally swaps the kernel during CALC, and checks
    // latency, accept spacing and the returned result.
    task automatic applyStimulus(input logic [7:0] din, input logic [31:0] kern,
                                 input logic [31:0] kernLate, input logic [15:0] expRes,
                                 input logic chkGap);
        int acceptCyc;
        bit got;
        in_data  = din;
        kernel   = Conv::data_vector'(kern);
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("accept", 32'(got), 32'd1);
        acceptCyc = cyc;
        if (chkGap && prevAccept >= 0) begin
            checkOutput("accept gap", 32'(acceptCyc - prevAccept), 32'd6);
        end
        prevAccept = acceptCyc;
        @(negedge clk);
        in_valid = 1'b0;
        kernel   = Conv::data_vector'(kernLate);
        waitValid(got);
        checkOutput("out_valid seen", 32'(got), 32'd1);
        checkOutput("latency", 32'(cyc - acceptCyc), 32'd5);
        checkOutput("result", 32'(result), 32'(expRes));
    endtask

    initial begin
        bit got;
        int seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        kernel    = '0;
        out_ready = 1'b1;

        vecs[0] = '{1'b1, 1'b0, 8'h05, 32'h04030201, 16'd20};
        vecs[1] = '{1'b0, 1'b1, 8'h06, 32'h04030201, 16'd39};
        vecs[2] = '{1'b0, 1'b1, 8'h07, 32'h04030201, 16'd56};
        vecs[3] = '{1'b0, 1'b1, 8'h08, 32'h04030201, 16'd70};
        vecs[4] = '{1'b1, 1'b0, 8'hFF, 32'hFFFFFFFF, 16'hFE01};
        vecs[5] = '{1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 16'hFC02};
        vecs[6] = '{1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 16'hFA03};
        vecs[7] = '{1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 16'hF804};
        vecs[8] = '{1'b0, 1'b1, 8'h10, 32'h01000000, 16'h0010};
        vecs[9] = '{1'b0, 1'b1, 8'h02, 32'h00000001, 16'h00FF};

        @(negedge clk);
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].doReset) applyReset();
            applyStimulus(vecs[v].din, vecs[v].kern, vecs[v].kern, vecs[v].expRes, vecs[v].chkGap);
        end

        // Backpressure: result held for 10 cycles while a new sample is offered.
        applyReset();
        out_ready = 1'b0;
        applyStimulus(8'h05, 32'h04030201, 32'h04030201, 16'd20, 1'b0);
        in_data  = 8'h33;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall result", 32'(result), 32'd20);
            checkOutput("stall in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after handshake", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        waitValid(got);
        checkOutput("post-stall out_valid", 32'(got), 32'd1);
        checkOutput("post-stall result", 32'(result), 32'd219);

        // Kernel changed to all 9s during CALC must not affect the result.
        prevAccept = -1;
        applyStimulus(8'h01, 32'h04030201, 32'h09090909, 16'd167, 1'b0);

        // Reset in CALC cycle C2 discards the computation and clears the window.
        @(negedge clk);
        in_data  = 8'h07;
        kernel   = Conv::data_vector'(32'h04030201);
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("mid-reset accept", 32'(got), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checkOutput("no result after mid reset", 32'(seen), 32'd0);
        prevAccept = -1;
        applyStimulus(8'h05, 32'h04030201, 32'h04030201, 16'd20, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
